hazard_ctrl_unit: RTL and testbench

//  Pipeline hazard controller that drives the enable/flush inputs of the PC and the
//  IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers of the 5-stage MIPS core.
//  - Inserts exactly one bubble on a load-use hazard.
//  - Flushes IF/ID on a taken branch or jump.
//  - Freezes the pipeline while data memory is busy, with a watchdog on that wait.
//  - Sequential on the falling clock edge, the same edge the pipe registers use.

---
 rtl/hazard_ctrl_unit.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller for the 5-stage MIPS core. It drives the PC and
//   pipe-register enables and flushes for three cases:
//     - a load-use hazard, which inserts exactly one bubble
//     - a taken branch or jump, which flushes IF/ID
//     - a busy data memory, which freezes the pipeline under a watchdog
//   All state updates on the falling clock edge, the same edge the pipe
//   registers use.
//   Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cnt and
//   flush_cnt performance counters.
module hazard_ctrl_unit #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic [1:0]       state,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  state_t           cur_state, nxt_state;
  logic             pending_redirect, pending_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             timeout_nxt;
  logic             lu_hazard;

  // A load in EX writes a register that the instruction in ID reads; $zero never hazards
  assign lu_hazard = ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign state = cur_state;

  // Prioritised output decode and next-state selection
  always_comb begin
    // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    nxt_state    = RUN;
    pending_nxt  = pending_redirect;

    if (mem_busy) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      nxt_state    = MEM_WAIT;
      pending_nxt  = pending_redirect | id_redirect;
    end else if (lu_hazard && (cur_state != LU_STALL)) begin
      // The redirect is ignored here; ID still holds the same instruction next cycle
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      nxt_state   = LU_STALL;
    end else if (id_redirect || pending_redirect) begin
      if_id_flush = 1'b1;
      nxt_state   = FLUSH;
      pending_nxt = 1'b0;
    end
  end

  // The memory-wait watchdog counts consecutive busy cycles and saturates
  always_comb begin
    wait_cnt_nxt = '0;
    if (mem_busy)
      wait_cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    timeout_nxt = timeout_err | (mem_busy && (wait_cnt_nxt >= WAIT_LIM));
  end

  // Control state register, updated on the falling edge with the pipe registers
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cur_state        <= RUN;
      pending_redirect <= 1'b0;
      wait_cnt         <= '0;
      timeout_err      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment, so every register samples pre-edge values.
      cur_state        <= nxt_state;
      pending_redirect <= pending_nxt;
      wait_cnt         <= wait_cnt_nxt;
      timeout_err      <= timeout_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of stalled-PC cycles and IF/ID flush cycles
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
//   Directed bench for hazard_ctrl_unit. Inputs change just after the rising
//   edge. Combinational outputs are sampled 1 ns later. Registered state is
//   sampled 1 ns after the falling (active) edge.
module tb_hazard_ctrl_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  // Packed output vector:
  //   {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [6:0] O_NORM = 7'b1101010;
  localparam logic [6:0] O_MEMB = 7'b0000001;
  localparam logic [6:0] O_LU   = 7'b0001110;
  localparam logic [6:0] O_REDR = 7'b1111010;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, id_redirect, mem_busy;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_en, mem_wb_flush, timeout_err;
  logic [1:0]       state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif
  logic [6:0]       outs;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit #(.REG_W(REG_W), .MAX_WAIT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_redirect(id_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .state(state),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .timeout_err(timeout_err)
  );

  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [REG_W-1:0] rs, rt, xrt;
    logic             uses_rt, mrd, redir, busy;
    logic [6:0]       exp_outs;
    logic [1:0]       exp_state;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [REG_W-1:0] rs, rt, xrt,
                       input logic uses_rt, mrd, redir, busy);
    id_rs = rs; id_rt = rt; ex_rt = xrt;
    id_uses_rt = uses_rt; ex_mem_read = mrd; id_redirect = redir; mem_busy = busy;
  endtask

  // Drive one cycle of inputs, check the outputs, then check the registered state
  task automatic step(input string name, input logic [REG_W-1:0] rs, rt, xrt,
                      input logic uses_rt, mrd, redir, busy,
                      input logic [6:0] eo, input logic [1:0] es);
    @(posedge clk);
    drive(rs, rt, xrt, uses_rt, mrd, redir, busy);
    #1 check({name, " outs"}, 32'(outs), 32'(eo));
    @(negedge clk);
    #1 check({name, " state"}, 32'(state), 32'(es));
  endtask

  vec_t vecs[16];

  initial begin
    //          rs  rt  xrt uses mrd redir busy  outs    state
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0};
    vecs[1]  = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, O_LU,   2'd1};
    vecs[2]  = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, O_NORM, 2'd0};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_NORM, 2'd0};
    vecs[4]  = '{5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, O_LU,   2'd1};
    vecs[5]  = '{5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0};
    vecs[6]  = '{5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, O_NORM, 2'd0};
    vecs[7]  = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, O_LU,   2'd1};
    vecs[8]  = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, O_REDR, 2'd3};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_REDR, 2'd3};
    vecs[11] = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, O_MEMB, 2'd2};
    vecs[12] = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, O_LU,   2'd1};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0};
    vecs[14] = '{5'd31, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, O_LU, 2'd1};
    vecs[15] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0};

    // Reset
    reset = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset timeout", 32'(timeout_err), 32'd0);
    check("reset outs", 32'(outs), 32'(O_NORM));
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++)
      step($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, vecs[i].xrt, vecs[i].uses_rt,
           vecs[i].mrd, vecs[i].redir, vecs[i].busy, vecs[i].exp_outs, vecs[i].exp_state);

    // Redirect pulse during a 3-cycle memory wait is replayed once afterwards
    step("mw1", '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, O_MEMB, 2'd2);
    step("mw2", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, O_MEMB, 2'd2);
    step("mw3", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, O_MEMB, 2'd2);
    step("mw4", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, O_REDR, 2'd3);
    step("mw5", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0);

    // Watchdog: sets after the 15th consecutive busy cycle and is sticky
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      if (c == 14) check("timeout after 14", 32'(timeout_err), 32'd0);
      if (c == 15) check("timeout after 15", 32'(timeout_err), 32'd1);
    end
    check("timeout wait state", 32'(state), 32'd2);
    step("after wait", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM, 2'd0);
    check("timeout sticky", 32'(timeout_err), 32'd1);

    // Reset during MEM_WAIT with a pending redirect drops the redirect
    step("rw1", '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, O_MEMB, 2'd2);
    step("rw2", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, O_MEMB, 2'd2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async reset state", 32'(state), 32'd0);
    check("async reset timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    @(posedge clk);
    reset = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("post reset outs", 32'(outs), 32'(O_NORM));
    @(negedge clk);
    #1 check("post reset state", 32'(state), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt zero", 32'(stall_cnt), 32'd0);
    check("flush_cnt zero", 32'(flush_cnt), 32'd0);
    step("pc1", 5'd4, '0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, O_LU, 2'd1);
    step("pc2", '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, O_REDR, 2'd3);
    step("pc3", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, O_MEMB, 2'd2);
    check("stall_cnt", 32'(stall_cnt), 32'd2);
    check("flush_cnt", 32'(flush_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
